rca_grid_cfg_ctrl: RTL and testbench

//  Configuration sequencer for the RCA PR grid. On request, fetches one stored grid configuration
//  (grid xbar selects, IO mux selects, IO output modes) word-by-word from the config RAM into shadow

---
 rtl/rca_grid_cfg_ctrl_pkg.sv | 43 ++++
 rtl/rca_grid_cfg_ctrl_if.sv | 25 ++
 rtl/rca_grid_cfg_ctrl_decoder.sv | 36 +++
 rtl/rca_grid_cfg_ctrl.sv | 159 +++++++++++++++
 tb/tb_rca_grid_cfg_ctrl.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rca_grid_cfg_ctrl_pkg.sv
// Shared sizing, word map and types for the RCA PR-grid configuration sequencer.
// Request ids carry one spare bit so that out-of-range ids reach the controller and can be rejected.
package rca_config;

  localparam int GRID_NUM_ROWS      = 3;
  localparam int GRID_NUM_COLS      = 3;
  localparam int GRID_MUX_INPUTS    = 5;
  localparam int IO_UNIT_MUX_INPUTS = 6;
  localparam int NUM_CONFIGS        = 4;
  localparam int CFG_W              = 8;

  localparam int NUM_IO_UNITS   = GRID_NUM_ROWS + 1;
  localparam int NUM_GRID_MUXES = GRID_NUM_ROWS * GRID_NUM_COLS;
  localparam int NUM_GRID_SELS  = 2 * NUM_GRID_MUXES;
  localparam int CFG_WORDS      = 2 * NUM_GRID_MUXES + 2 * NUM_IO_UNITS;

  // Word map inside one stored configuration
  localparam int IO_SEL_BASE = NUM_GRID_SELS;
  localparam int MODE_BASE   = IO_SEL_BASE + NUM_IO_UNITS;

  localparam int GRID_SEL_W = $clog2(GRID_MUX_INPUTS);
  localparam int IO_SEL_W   = $clog2(IO_UNIT_MUX_INPUTS);
  localparam int MAX_SEL_W  = (GRID_SEL_W > IO_SEL_W) ? GRID_SEL_W : IO_SEL_W;
  localparam int CFG_ID_W   = $clog2(NUM_CONFIGS);
  localparam int REQ_ID_W   = CFG_ID_W + 1;
  localparam int ADDR_W     = $clog2(NUM_CONFIGS * CFG_WORDS);
  localparam int WORD_IDX_W = $clog2(CFG_WORDS + 1);

  typedef logic [GRID_SEL_W-1:0] grid_sel_t;
  typedef logic [IO_SEL_W-1:0]   io_sel_t;

  typedef enum logic [1:0] {
    CFG_IDLE,
    CFG_DRAIN,
    CFG_FETCH,
    CFG_COMMIT
  } cfg_state_t;

  function automatic logic [ADDR_W-1:0] cfg_base(input logic [CFG_ID_W-1:0] id);
    return ADDR_W'(int'(id) * CFG_WORDS);
  endfunction

endpackage

// File: rtl/rca_grid_cfg_ctrl_if.sv
// Load handshake and config-RAM read bus between the issue logic/RAM (master) and the sequencer (slave).
interface rca_grid_cfg_ctrl_if;
  import rca_config::*;

  logic                load_req;
  logic [REQ_ID_W-1:0] cfg_id;
  logic                load_ack;
  logic                load_err;
  logic                load_done;
  logic                busy;
  logic                cfg_rd_en;
  logic [ADDR_W-1:0]   cfg_rd_addr;
  logic [CFG_W-1:0]    cfg_rd_data;

  modport master (
    output load_req, cfg_id, cfg_rd_data,
    input  load_ack, load_err, load_done, busy, cfg_rd_en, cfg_rd_addr
  );

  modport slave (
    input  load_req, cfg_id, cfg_rd_data,
    output load_ack, load_err, load_done, busy, cfg_rd_en, cfg_rd_addr
  );

endinterface

// File: rtl/rca_grid_cfg_ctrl_decoder.sv
// Maps a config word index and its data onto shadow-register write enables and truncated field values.
module rca_cfg_word_decoder
  import rca_config::*;
(
  input  logic                     wr_en,
  input  logic [WORD_IDX_W-1:0]    word_idx,
  input  logic [CFG_W-1:0]         word_data,
  output logic [NUM_GRID_SELS-1:0] grid_we,
  output logic [NUM_IO_UNITS-1:0]  io_sel_we,
  output logic [NUM_IO_UNITS-1:0]  mode_we,
  output grid_sel_t                grid_val,
  output io_sel_t                  io_val,
  output logic                     mode_val
);

  logic unused_data_bits;
  assign unused_data_bits = ^word_data[CFG_W-1:MAX_SEL_W];

  // Fields wider than their select are cut down to the LSBs
  always_comb begin
    grid_we   = '0;
    io_sel_we = '0;
    mode_we   = '0;
    grid_val  = word_data[GRID_SEL_W-1:0];
    io_val    = word_data[IO_SEL_W-1:0];
    mode_val  = word_data[0];
    for (int i = 0; i < NUM_GRID_SELS; i++) begin
      grid_we[i] = wr_en && (word_idx == WORD_IDX_W'(i));
    end
    for (int j = 0; j < NUM_IO_UNITS; j++) begin
      io_sel_we[j] = wr_en && (word_idx == WORD_IDX_W'(IO_SEL_BASE + j));
      mode_we[j]   = wr_en && (word_idx == WORD_IDX_W'(MODE_BASE + j));
    end
  end

endmodule

// File: rtl/rca_grid_cfg_ctrl.sv
// RCA PR-grid configuration sequencer: drain, fetch into shadow registers, then commit atomically.
// Optional RCA_CFG_REUSE_EN: a request for the already-active config completes in its ack cycle.
module rca_grid_cfg_ctrl
  import rca_config::*;
(
  input  logic                               clk,
  input  logic                               rst,
  rca_grid_cfg_ctrl_if.slave                 cfg_bus,
  input  logic                               grid_busy,
  output grid_sel_t [NUM_GRID_SELS-1:0]      grid_mux_sel,
  output io_sel_t   [NUM_IO_UNITS-1:0]       curr_io_mux_sels,
  output logic      [NUM_IO_UNITS-1:0]       io_unit_output_mode,
  output logic                               io_units_rst,
  output logic      [CFG_ID_W-1:0]           active_cfg_id,
  output logic                               active_valid
);

  cfg_state_t state, state_nxt;
  logic [WORD_IDX_W-1:0] word_cnt, word_cnt_nxt;
  logic [CFG_ID_W-1:0]   pend_id;
  logic                  id_latch;
  logic                  capture;
  logic                  commit;
  logic                  req_valid;

  grid_sel_t [NUM_GRID_SELS-1:0] shadow_grid;
  io_sel_t   [NUM_IO_UNITS-1:0]  shadow_io;
  logic      [NUM_IO_UNITS-1:0]  shadow_mode;

  logic [NUM_GRID_SELS-1:0] grid_we;
  logic [NUM_IO_UNITS-1:0]  io_sel_we;
  logic [NUM_IO_UNITS-1:0]  mode_we;
  grid_sel_t                grid_val;
  io_sel_t                  io_val;
  logic                     mode_val;

  assign req_valid    = cfg_bus.cfg_id < REQ_ID_W'(NUM_CONFIGS);
  assign cfg_bus.busy = (state != CFG_IDLE);

`ifdef RCA_CFG_REUSE_EN
  logic req_hit;
  assign req_hit = active_valid && (cfg_bus.cfg_id == REQ_ID_W'(active_cfg_id));
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= CFG_IDLE;
      word_cnt <= '0;
      pend_id  <= '0;
    end else begin
      state    <= state_nxt;
      word_cnt <= word_cnt_nxt;
      if (id_latch) pend_id <= cfg_bus.cfg_id[CFG_ID_W-1:0];
    end
  end

  // Word 0 is issued in the DRAIN exit cycle; FETCH captures word_cnt-1 and issues word_cnt
  always_comb begin
    state_nxt           = state;
    word_cnt_nxt        = word_cnt;
    id_latch            = 1'b0;
    capture             = 1'b0;
    commit              = 1'b0;
    cfg_bus.load_ack    = 1'b0;
    cfg_bus.load_err    = 1'b0;
    cfg_bus.load_done   = 1'b0;
    cfg_bus.cfg_rd_en   = 1'b0;
    cfg_bus.cfg_rd_addr = '0;
    io_units_rst        = 1'b0;
    unique case (state)
      CFG_IDLE: begin
        if (cfg_bus.load_req && !rst) begin
          cfg_bus.load_ack = 1'b1;
          if (!req_valid) begin
            cfg_bus.load_err = 1'b1;
`ifdef RCA_CFG_REUSE_EN
          end else if (req_hit) begin
            cfg_bus.load_done = 1'b1;
`endif
          end else begin
            id_latch  = 1'b1;
            state_nxt = CFG_DRAIN;
          end
        end
      end
      CFG_DRAIN: begin
        if (!grid_busy) begin
          cfg_bus.cfg_rd_en   = 1'b1;
          cfg_bus.cfg_rd_addr = cfg_base(pend_id);
          word_cnt_nxt        = WORD_IDX_W'(1);
          state_nxt           = CFG_FETCH;
        end
      end
      CFG_FETCH: begin
        capture = 1'b1;
        if (word_cnt == WORD_IDX_W'(CFG_WORDS)) begin
          state_nxt = CFG_COMMIT;
        end else begin
          cfg_bus.cfg_rd_en   = 1'b1;
          cfg_bus.cfg_rd_addr = cfg_base(pend_id) + ADDR_W'(word_cnt);
          word_cnt_nxt        = word_cnt + WORD_IDX_W'(1);
        end
      end
      CFG_COMMIT: begin
        commit            = 1'b1;
        cfg_bus.load_done = 1'b1;
        io_units_rst      = 1'b1;
        state_nxt         = CFG_IDLE;
      end
      default: state_nxt = CFG_IDLE;
    endcase
  end

  rca_cfg_word_decoder u_word_decoder (
    .wr_en     (capture),
    .word_idx  (word_cnt - WORD_IDX_W'(1)),
    .word_data (cfg_bus.cfg_rd_data),
    .grid_we   (grid_we),
    .io_sel_we (io_sel_we),
    .mode_we   (mode_we),
    .grid_val  (grid_val),
    .io_val    (io_val),
    .mode_val  (mode_val)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_grid <= '0;
      shadow_io   <= '0;
      shadow_mode <= '0;
    end else begin
      for (int i = 0; i < NUM_GRID_SELS; i++) begin
        if (grid_we[i]) shadow_grid[i] <= grid_val;
      end
      for (int j = 0; j < NUM_IO_UNITS; j++) begin
        if (io_sel_we[j]) shadow_io[j]   <= io_val;
        if (mode_we[j])   shadow_mode[j] <= mode_val;
      end
    end
  end

  // The grid only ever sees a fully fetched configuration
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grid_mux_sel        <= '0;
      curr_io_mux_sels    <= '0;
      io_unit_output_mode <= '0;
      active_cfg_id       <= '0;
      active_valid        <= 1'b0;
    end else if (commit) begin
      grid_mux_sel        <= shadow_grid;
      curr_io_mux_sels    <= shadow_io;
      io_unit_output_mode <= shadow_mode;
      active_cfg_id       <= pend_id;
      active_valid        <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rca_grid_cfg_ctrl.sv
// Self-checking bench for rca_grid_cfg_ctrl: RAM model, event monitor and spec-level expectations.
// Expectations follow RCA_CFG_REUSE_EN when it is defined for the build.
module tb_rca_grid_cfg_ctrl;
  import rca_config::*;

  localparam int MEM_WORDS    = NUM_CONFIGS * CFG_WORDS;
  localparam int IDLE_LATENCY = CFG_WORDS + 2;

  logic clk = 1'b0;
  logic rst;
  logic grid_busy;
  grid_sel_t [NUM_GRID_SELS-1:0] grid_mux_sel;
  io_sel_t   [NUM_IO_UNITS-1:0]  curr_io_mux_sels;
  logic      [NUM_IO_UNITS-1:0]  io_unit_output_mode;
  logic                          io_units_rst;
  logic      [CFG_ID_W-1:0]      active_cfg_id;
  logic                          active_valid;

  rca_grid_cfg_ctrl_if cfg_bus ();

  rca_grid_cfg_ctrl dut (
    .clk                 (clk),
    .rst                 (rst),
    .cfg_bus             (cfg_bus.slave),
    .grid_busy           (grid_busy),
    .grid_mux_sel        (grid_mux_sel),
    .curr_io_mux_sels    (curr_io_mux_sels),
    .io_unit_output_mode (io_unit_output_mode),
    .io_units_rst        (io_units_rst),
    .active_cfg_id       (active_cfg_id),
    .active_valid        (active_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  int glitch_cnt = 0;
  logic [CFG_W-1:0] mem [MEM_WORDS];
  int ack_q[$], done_q[$], err_q[$], iorst_q[$], rd_q[$], rd_cyc_q[$];
  logic [127:0] last_active = '0;
  bit prev_done = 1'b0;
  int model_id = 0;
  bit model_valid = 1'b0;

  always @(posedge clk) cycle++;

  // Config RAM: data valid the cycle after the read strobe
  always @(posedge clk) begin
    int a;
    a = int'(cfg_bus.cfg_rd_addr);
    if (cfg_bus.cfg_rd_en) cfg_bus.cfg_rd_data <= (a < MEM_WORDS) ? mem[a] : '0;
  end

  function automatic logic [127:0] active_now();
    return 128'({grid_mux_sel, curr_io_mux_sels, io_unit_output_mode, active_cfg_id, active_valid});
  endfunction

  // Event log plus a watch that active outputs only move right after a load_done
  always @(negedge clk) begin
    if (cfg_bus.load_ack)  ack_q.push_back(cycle);
    if (cfg_bus.load_done) done_q.push_back(cycle);
    if (cfg_bus.load_err)  err_q.push_back(cycle);
    if (io_units_rst)      iorst_q.push_back(cycle);
    if (cfg_bus.cfg_rd_en) begin
      rd_q.push_back(int'(cfg_bus.cfg_rd_addr));
      rd_cyc_q.push_back(cycle);
    end
    if (!rst && active_now() != last_active && !prev_done) glitch_cnt++;
    last_active = active_now();
    prev_done   = cfg_bus.load_done && !rst;
  end

  task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  function automatic int exp_field(input int id, input int w, input int width);
    return int'(mem[id * CFG_WORDS + w]) % (1 << width);
  endfunction

  task automatic clear_logs();
    ack_q.delete(); done_q.delete(); err_q.delete();
    iorst_q.delete(); rd_q.delete(); rd_cyc_q.delete();
  endtask

  // Raise a request, hold it until acked, then keep the grid busy for busy_cycles more cycles
  task automatic applyStimulus(input logic [REQ_ID_W-1:0] id, input int busy_cycles);
    int guard = 0;
    @(posedge clk); #1;
    cfg_bus.load_req = 1'b1;
    cfg_bus.cfg_id   = id;
    grid_busy        = (busy_cycles > 0);
    @(negedge clk);
    while (!cfg_bus.load_ack && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("ack_wait", cfg_bus.load_ack, 1'b1);
    @(posedge clk); #1;
    cfg_bus.load_req = 1'b0;
    repeat (busy_cycles) begin
      @(posedge clk); #1;
    end
    grid_busy = 1'b0;
  endtask

  task automatic wait_done(input int prior);
    int guard = 0;
    while (done_q.size() <= prior && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("done_wait", done_q.size() > prior, 1'b1);
    @(negedge clk);
  endtask

  task automatic check_config(input int id, input string tag);
    for (int i = 0; i < NUM_GRID_SELS; i++)
      checkOutput($sformatf("%s_grid%0d", tag, i), grid_mux_sel[i], exp_field(id, i, GRID_SEL_W));
    for (int j = 0; j < NUM_IO_UNITS; j++) begin
      checkOutput($sformatf("%s_io%0d", tag, j), curr_io_mux_sels[j], exp_field(id, 18 + j, IO_SEL_W));
      checkOutput($sformatf("%s_mode%0d", tag, j), io_unit_output_mode[j], exp_field(id, 22 + j, 1));
    end
    checkOutput({tag, "_id"}, active_cfg_id, id);
    checkOutput({tag, "_valid"}, active_valid, 1'b1);
  endtask

  task automatic check_addr_seq(input int first, input int id, input string tag);
    int bad = 0;
    for (int k = 0; k < CFG_WORDS; k++)
      if (first + k >= rd_q.size() || rd_q[first + k] != id * CFG_WORDS + k) bad++;
    checkOutput({tag, "_addr_seq"}, bad, 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired actual=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1;
    grid_busy = 1'b0;
    cfg_bus.load_req = 1'b0;
    cfg_bus.cfg_id = '0;
    for (int k = 0; k < MEM_WORDS; k++) mem[k] = CFG_W'(k);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);

    checkOutput("rst_active", active_now(), '0);
    checkOutput("rst_busy", cfg_bus.busy, 1'b0);
    checkOutput("rst_rd_en", cfg_bus.cfg_rd_en, 1'b0);
    checkOutput("rst_iorst", io_units_rst, 1'b0);
    clear_logs();

    // Basic load with RAM word k = k
    applyStimulus(3'd1, 0);
    wait_done(0);
    checkOutput("t1_latency", done_q[0] - ack_q[0], IDLE_LATENCY);
    checkOutput("t1_rd_count", rd_q.size(), CFG_WORDS);
    checkOutput("t1_first_addr", rd_q[0], 26);
    checkOutput("t1_last_addr", rd_q[CFG_WORDS-1], 51);
    check_addr_seq(0, 1, "t1");
    checkOutput("t1_grid0", grid_mux_sel[0], 2);
    checkOutput("t1_mode0", io_unit_output_mode[0], 0);
    check_config(1, "t1");
    checkOutput("t1_iorst_cnt", iorst_q.size(), 1);
    checkOutput("t1_iorst_cyc", iorst_q[0], done_q[0]);
    checkOutput("t1_no_err", err_q.size(), 0);
    model_id = 1; model_valid = 1'b1;

    for (int k = 0; k < MEM_WORDS; k++) mem[k] = CFG_W'($urandom);

    // Grid busy for 10 cycles after the ack
    clear_logs();
    applyStimulus(3'd2, 10);
    wait_done(0);
    checkOutput("t2_latency", done_q[0] - ack_q[0], IDLE_LATENCY + 10);
    checkOutput("t2_first_rd", rd_cyc_q[0] - ack_q[0], 11);
    checkOutput("t2_rd_count", rd_q.size(), CFG_WORDS);
    check_addr_seq(0, 2, "t2");
    check_config(2, "t2");
    model_id = 2;

    // Out-of-range ids: ack+err together, nothing else moves
    begin
      logic [127:0] snap;
      int bad_ids[3] = '{4, 5, 7};
      snap = active_now();
      clear_logs();
      foreach (bad_ids[n]) applyStimulus(REQ_ID_W'(bad_ids[n]), 0);
      repeat (5) @(negedge clk);
      checkOutput("t3_ack_cnt", ack_q.size(), 3);
      checkOutput("t3_err_cnt", err_q.size(), 3);
      checkOutput("t3_err_cyc", err_q[1], ack_q[1]);
      checkOutput("t3_no_rd", rd_q.size(), 0);
      checkOutput("t3_no_done", done_q.size(), 0);
      checkOutput("t3_active", active_now(), snap);
      checkOutput("t3_busy", cfg_bus.busy, 1'b0);
    end

    // Second request raised mid-fetch waits for the first commit
    clear_logs();
    applyStimulus(3'd0, 0);
    repeat (4) begin
      @(posedge clk); #1;
    end
    applyStimulus(3'd3, 0);
    wait_done(1);
    checkOutput("t4_ack_cnt", ack_q.size(), 2);
    checkOutput("t4_ack2_cyc", ack_q[1], done_q[0] + 1);
    checkOutput("t4_latency1", done_q[0] - ack_q[0], IDLE_LATENCY);
    checkOutput("t4_latency2", done_q[1] - ack_q[1], IDLE_LATENCY);
    checkOutput("t4_rd_count", rd_q.size(), 2 * CFG_WORDS);
    check_addr_seq(0, 0, "t4a");
    check_addr_seq(CFG_WORDS, 3, "t4b");
    check_config(3, "t4");
    checkOutput("t4_iorst_cnt", iorst_q.size(), 2);
    model_id = 3;

    // Reset while word 10 is being fetched
    clear_logs();
    applyStimulus(3'd1, 0);
    repeat (10) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(negedge clk);
    checkOutput("t5_rd_before", rd_q.size(), 10);
    checkOutput("t5_active", active_now(), '0);
    checkOutput("t5_rd_en", cfg_bus.cfg_rd_en, 1'b0);
    checkOutput("t5_busy", cfg_bus.busy, 1'b0);
    checkOutput("t5_iorst", io_units_rst, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (40) @(negedge clk);
    checkOutput("t5_no_done", done_q.size(), 0);
    checkOutput("t5_no_iorst", iorst_q.size(), 0);
    checkOutput("t5_valid", active_valid, 1'b0);
    model_valid = 1'b0;

    // Same id twice in a row
    clear_logs();
    applyStimulus(3'd2, 0);
    wait_done(0);
    check_config(2, "t6a");
    model_id = 2; model_valid = 1'b1;
    clear_logs();
    applyStimulus(3'd2, 0);
    wait_done(0);
`ifdef RCA_CFG_REUSE_EN
    checkOutput("t6_latency", done_q[0] - ack_q[0], 0);
    checkOutput("t6_rd_count", rd_q.size(), 0);
    checkOutput("t6_iorst", iorst_q.size(), 0);
`else
    checkOutput("t6_latency", done_q[0] - ack_q[0], IDLE_LATENCY);
    checkOutput("t6_rd_count", rd_q.size(), CFG_WORDS);
    checkOutput("t6_iorst", iorst_q.size(), 1);
`endif
    check_config(2, "t6b");

    // Random ids and drain lengths against the model
    for (int it = 0; it < 8; it++) begin
      int id, busy_n;
      bit reuse;
      id = $urandom_range(0, NUM_CONFIGS - 1);
      busy_n = $urandom_range(0, 4);
`ifdef RCA_CFG_REUSE_EN
      reuse = model_valid && (id == model_id);
`else
      reuse = 1'b0;
`endif
      clear_logs();
      applyStimulus(REQ_ID_W'(id), busy_n);
      wait_done(0);
      checkOutput($sformatf("r%0d_latency", it), done_q[0] - ack_q[0],
                  reuse ? 0 : IDLE_LATENCY + busy_n);
      checkOutput($sformatf("r%0d_rd_count", it), rd_q.size(), reuse ? 0 : CFG_WORDS);
      if (!reuse) check_addr_seq(0, id, $sformatf("r%0d", it));
      check_config(id, $sformatf("r%0d", it));
      model_id = id; model_valid = 1'b1;
    end

    checkOutput("no_partial_update", glitch_cnt, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
